enc1s_seq: RTL

ENC1S_SEQ -- requirements
Module: enc1s_seq

---
 rtl/enc1s_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/enc1s_seq.sv
// -----------------------------------------------------------------------------
// enc1s_seq
// Sequencer that drives an external combinational enc1s unit over LANES
// byte-lane steps. A job supplies an operation class, an initial accumulator
// and a source word. Each RUN cycle feeds the accumulator back through the
// unit, with fn = {op, byte_select}. The final accumulator is then presented
// on a valid/ready result port.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   job request valid
//   in_ready   out  1   high exactly in IDLE
//   in_op      in   3   operation class, becomes fn[4:2]
//   in_acc     in  32   initial accumulator, first rs1
//   in_src     in  32   source word, rs2 for every step
//   e_rs1      out 32   rs1 to the enc1s unit
//   e_rs2      out 32   rs2 to the enc1s unit
//   e_fn       out  5   {op, byte_select} to the enc1s unit
//   e_rd       in  32   combinational result from the enc1s unit
//   out_valid  out  1   high exactly in DONE
//   out_ready  in   1   consumer accepts the result
//   out_data   out 32   final accumulated word
// -----------------------------------------------------------------------------
module enc1s_seq #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_acc,
    input  logic [31:0] in_src,
    output logic [31:0] e_rs1,
    output logic [31:0] e_rs2,
    output logic [4:0]  e_fn,
    input  logic [31:0] e_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Index of the final RUN step. The counter never wraps within a job
    // because LANES is at most 4.
    localparam logic [2:0] LAST_STEP = 3'(LANES - 1);

    state_e      state_q, state_d;
    logic [31:0] acc_q,   acc_d;
    logic [2:0]  step_q,  step_d;
    logic [2:0]  op_q,    op_d;
    logic [31:0] src_q,   src_d;
    logic [31:0] rs1_q,   rs1_d;
    logic [4:0]  fn_q,    fn_d;

    logic [2:0]  step_inc_s;
    logic        last_step_s;

    assign step_inc_s  = step_q + 3'd1;
    assign last_step_s = (step_q == LAST_STEP);

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        op_d    = op_q;
        src_d   = src_q;
        rs1_d   = rs1_q;
        fn_d    = fn_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    op_d    = in_op;
                    src_d   = in_src;
                    acc_d   = in_acc;
                    step_d  = 3'd0;
                    // Preload the unit operands so step 0 is presented
                    // during the first RUN cycle.
                    rs1_d   = in_acc;
                    fn_d    = {in_op, 2'b00};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d  = e_rd;
                step_d = step_inc_s;
                if (last_step_s) begin
                    // The operand registers keep the last step's values.
                    // The unit inputs are therefore quiet in DONE and in IDLE.
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    rs1_d   = e_rd;
                    fn_d    = {op_q, step_inc_s[1:0]};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'd0;
            step_q  <= 3'd0;
            op_q    <= 3'd0;
            src_q   <= 32'd0;
            rs1_q   <= 32'd0;
            fn_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            op_q    <= op_d;
            src_q   <= src_d;
            rs1_q   <= rs1_d;
            fn_q    <= fn_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign e_rs1     = rs1_q;
    assign e_rs2     = src_q;
    assign e_fn      = fn_q;

endmodule
